masked_rand_source: RTL and testbench

- Fresh-randomness supplier that sits directly upstream of the masked HPC3 multipliers.
- Drives one multiplier's in_r and in_p operand buses every cycle from a seeded leap-forward LFSR.
- Adds seed handshake, warm-up sequencing, stall control and an output-valid flag, so multiplier chains only consume randomness once the LFSR is properly mixed.

---
 rtl/masked_rand_source_pkg.sv | 32 +++
 rtl/masked_rand_source_lfsr64_leap.sv | 28 ++
 rtl/masked_rand_source.sv | 117 +++++++++++
 tb/tb_masked_rand_source.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/masked_rand_source_pkg.sv
//==============================================================================
// masked_rand_source_pkg : shared types and helpers for randomness sources.
// Revision: 1.0
//==============================================================================
`default_nettype none

package masked_rand_source_pkg;

    localparam int          RAND_LFSR_WIDTH        = 64;
    localparam logic [63:0] RAND_LFSR_DEFAULT_SEED = 64'h1;

    typedef logic [RAND_LFSR_WIDTH-1:0] lfsr_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } rand_state_t;

    // Number of cross-share products an HPC3 multiplier refreshes.
    function automatic int num_quad(input int shares);
        return (shares * (shares - 1)) / 2;
    endfunction

    // Single Fibonacci step, polynomial x^64+x^63+x^61+x^60+1.
    function automatic lfsr_state_t lfsr_step(input lfsr_state_t s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/masked_rand_source_lfsr64_leap.sv
//==============================================================================
// lfsr64_leap : purely combinational STEPS-step advance of the 64-bit LFSR.
// Revision: 1.0
//==============================================================================
`default_nettype none

module lfsr64_leap
    import masked_rand_source_pkg::*;
#(
    parameter int STEPS = 2
) (
    input  logic [63:0] state_in,
    output logic [63:0] state_out
);

    lfsr_state_t acc;

    always_comb begin
        acc = state_in;
        for (int i = 0; i < STEPS; i++) begin
            acc = lfsr_step(acc);
        end
        state_out = acc;
    end

endmodule

`default_nettype wire

// File: rtl/masked_rand_source.sv
//==============================================================================
// masked_rand_source : seeded, warmed-up LFSR randomness feed for HPC3 multipliers.
// Optional macro MASKED_RAND_FORCE_ZERO_EN ties out_r/out_p to zero for debug.
// Revision: 1.0
//==============================================================================
`default_nettype none

module masked_rand_source
    import masked_rand_source_pkg::*;
#(
    parameter  int NUM_SHARES    = 2,
    parameter  int BIT_WIDTH     = 1,
    parameter  int WARMUP_CYCLES = 16,
    localparam int NUM_QUADRATIC = num_quad(NUM_SHARES),
    localparam int WORD_BITS     = NUM_QUADRATIC * BIT_WIDTH
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    input  logic [63:0]          in_seed,
    input  logic                 in_seed_valid,
    output logic                 out_seed_ready,
    input  logic                 in_enable,
    output logic [WORD_BITS-1:0] out_r,
    output logic [WORD_BITS-1:0] out_p,
    output logic                 out_valid
);

    localparam int         LEAP        = 2 * WORD_BITS;
    localparam logic [7:0] WARMUP_LAST = 8'(WARMUP_CYCLES - 1);

    if (LEAP > RAND_LFSR_WIDTH) begin : g_bad_leap
        $error("masked_rand_source: leap distance %0d exceeds LFSR width", LEAP);
    end
    if ((WARMUP_CYCLES < 1) || (WARMUP_CYCLES > 255)) begin : g_bad_warmup
        $error("masked_rand_source: WARMUP_CYCLES %0d out of range", WARMUP_CYCLES);
    end

    rand_state_t state_q, state_d;
    logic [7:0]  warm_cnt_q, warm_cnt_d;
    lfsr_state_t lfsr_q, lfsr_next, seed_load;
    logic        advance;

    lfsr64_leap #(
        .STEPS (LEAP)
    ) u_leap (
        .state_in  (lfsr_q),
        .state_out (lfsr_next)
    );

    // A zero seed would lock the LFSR; substitute the default seed.
    assign seed_load = (in_seed == 64'h0) ? RAND_LFSR_DEFAULT_SEED : in_seed;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        advance    = 1'b0;
        case (state_q)
            IDLE: ;
            WARMUP: begin
                if (in_enable) begin
                    advance    = 1'b1;
                    warm_cnt_d = warm_cnt_q + 8'd1;
                    if (warm_cnt_q == WARMUP_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                advance = in_enable;
            end
            default: state_d = IDLE;
        endcase
        // Seed acceptance wins over everything, including an enabled advance.
        if (in_seed_valid) begin
            state_d    = WARMUP;
            warm_cnt_d = 8'd0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            state_q    <= IDLE;
            warm_cnt_q <= 8'd0;
            lfsr_q     <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            if (in_seed_valid) begin
                lfsr_q <= seed_load;
            end else if (advance) begin
                lfsr_q <= lfsr_next;
            end
        end
    end

`ifdef MASKED_RAND_FORCE_ZERO_EN
    assign out_r = '0;
    assign out_p = '0;
`else
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            out_r <= '0;
            out_p <= '0;
        end else if (advance) begin
            out_r <= lfsr_next[WORD_BITS-1:0];
            out_p <= lfsr_next[LEAP-1:WORD_BITS];
        end
    end
`endif

    assign out_valid      = (state_q == RUN);
    assign out_seed_ready = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_masked_rand_source.sv
//==============================================================================
// tb_masked_rand_source : directed self-checking bench for masked_rand_source.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_masked_rand_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] seed;
    logic        seed_valid;
    logic        seed_ready;
    logic        enable;
    logic [0:0]  r;
    logic [0:0]  p;
    logic        valid;

    always #5 clk = ~clk;

    masked_rand_source #(
        .NUM_SHARES    (2),
        .BIT_WIDTH     (1),
        .WARMUP_CYCLES (16)
    ) dut (
        .in_clock       (clk),
        .in_reset       (rst_n),
        .in_seed        (seed),
        .in_seed_valid  (seed_valid),
        .out_seed_ready (seed_ready),
        .in_enable      (enable),
        .out_r          (r),
        .out_p          (p),
        .out_valid      (valid)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] m;
    logic [0:0]  er = 1'b0;
    logic [0:0]  ep = 1'b0;

    function automatic logic [63:0] ref_step(input logic [63:0] s);
        logic fb;
        fb = s[63] ^ s[62] ^ s[60] ^ s[59];
        return {s[62:0], fb};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Two single steps per enabled cycle; newest feedback bit lands in bit 0.
    task automatic model_adv();
        m = ref_step(ref_step(m));
`ifdef MASKED_RAND_FORCE_ZERO_EN
        er = 1'b0;
        ep = 1'b0;
`else
        er = m[0];
        ep = m[1];
`endif
    endtask

    task automatic load_seed(input logic [63:0] s, input logic en);
        seed       = s;
        seed_valid = 1'b1;
        enable     = en;
        cyc();
        seed_valid = 1'b0;
        m          = (s == 64'h0) ? 64'h1 : s;
    endtask

    task automatic warm_up(input string tag);
        for (int i = 1; i <= 16; i++) begin
            enable = 1'b1;
            cyc();
            model_adv();
            check_eq({tag, "_valid"}, 64'(valid), 64'(i == 16));
        end
        check_eq({tag, "_first_r"}, 64'(r), 64'(er));
        check_eq({tag, "_first_p"}, 64'(p), 64'(ep));
    endtask

    task automatic run_cmp(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            cyc();
            model_adv();
            check_eq({tag, "_r"}, 64'(r), 64'(er));
            check_eq({tag, "_p"}, 64'(p), 64'(ep));
            check_eq({tag, "_valid"}, 64'(valid), 64'd1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        seed       = 64'h0;
        seed_valid = 1'b0;
        enable     = 1'b0;
        m          = 64'h0;
        repeat (3) cyc();
        check_eq("rst_r", 64'(r), 64'd0);
        check_eq("rst_p", 64'(p), 64'd0);
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_ready", 64'(seed_ready), 64'd1);

        // Enable without a seed must leave IDLE untouched.
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (10) cyc();
        check_eq("idle_r", 64'(r), 64'd0);
        check_eq("idle_p", 64'(p), 64'd0);
        check_eq("idle_valid", 64'(valid), 64'd0);

        load_seed(64'h0123456789ABCDEF, 1'b1);
        check_eq("seed_valid_low", 64'(valid), 64'd0);
        check_eq("warm_ready", 64'(seed_ready), 64'd1);
        warm_up("a_warm");
        run_cmp("a_run", 1000);

        // Stall: everything must hold, then resume without skipping a word.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq("stall_r", 64'(r), 64'(er));
            check_eq("stall_p", 64'(p), 64'(ep));
            check_eq("stall_valid", 64'(valid), 64'd1);
        end
        run_cmp("resume", 30);

        // Reseed with enable high: no advance on the accept edge.
        load_seed(64'hFEDCBA9876543210, 1'b1);
        check_eq("reseed_valid", 64'(valid), 64'd0);
        check_eq("reseed_hold_r", 64'(r), 64'(er));
        check_eq("reseed_hold_p", 64'(p), 64'(ep));
        warm_up("b_warm");
        run_cmp("b_run", 100);

        // Zero seed behaves as seed 1; disabled cycles do not count toward warm-up.
        load_seed(64'h0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 8) begin
                enable = 1'b0;
                repeat (3) begin
                    cyc();
                    check_eq("z_gap_valid", 64'(valid), 64'd0);
                end
            end
            enable = 1'b1;
            cyc();
            model_adv();
            check_eq("z_warm_valid", 64'(valid), 64'(i == 16));
        end
        run_cmp("zero_seed", 100);

        // Reset during warm-up returns to IDLE values.
        load_seed(64'h5A5A5A5A0F0F0F0F, 1'b1);
        repeat (5) cyc();
        rst_n = 1'b0;
        cyc();
        er = 1'b0;
        ep = 1'b0;
        check_eq("mid_rst_r", 64'(r), 64'd0);
        check_eq("mid_rst_p", 64'(p), 64'd0);
        check_eq("mid_rst_valid", 64'(valid), 64'd0);
        check_eq("mid_rst_ready", 64'(seed_ready), 64'd1);
        rst_n = 1'b1;
        repeat (20) cyc();
        check_eq("post_rst_idle_valid", 64'(valid), 64'd0);
        check_eq("post_rst_idle_r", 64'(r), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
